sqrt2_sched: RTL
================

// Module: sqrt2_sched
// PURPOSE
//  Round-robin scheduler that shares one sqrt2 half-precision square-root unit among N_REQ requesters.
//  - Accepts one 16-bit operand per grant and drives it onto the shared tristate sqrt2 data bus.
//  - Holds the unit's ENABLE, waits for a result or special-case flag, then returns the tagged response.
//  - Flushes the unit (ENABLE low) before the next grant; one operation in flight at a time.
// PARAMETERS
//  N_REQ       4   number of requesters (2..8)
//  ID_W        2   requester id width, >= clog2(N_REQ)
//  LOAD_CYC    1   cycles operand is driven with SQ_ENABLE high (1..4)
//  TIMEOUT     64  max WAIT cycles before forced completion (>= 8)
// PORTS
//  CLK         in   1         clock, all state on rising edge
//  RST         in   1         asynchronous reset, active-high
//  REQ_VALID   in   N_REQ     requester i has an operand pending
//  REQ_DATA    in   16*N_REQ  operand of requester i in bits [16i+15:16i], fp16
//  REQ_READY   out  N_REQ     one-hot single-cycle accept; operand consumed that cycle
//  RSP_VALID   out  1         single-cycle response strobe, no backpressure
//  RSP_ID      out  ID_W      index of requester owning the response
//  RSP_DATA    out  16        fp16 result; 16'h0000 when no RESULT (flag-only or timeout)
//  RSP_FLAGS   out  3         {nan, pinf, ninf} as sampled from the unit
//  RSP_TIMEOUT out  1         response was forced by the timeout
//  BUSY        out  1         high in every state except IDLE
//  SQ_DATA     inout 16       shared bus to sqrt2 data port
//  SQ_ENABLE   out  1         sqrt2 ENABLE
//  SQ_RESULT   in   1         sqrt2 RESULT; unit drives SQ_DATA while high
//  SQ_IS_NAN / SQ_IS_PINF / SQ_IS_NINF  in  1 each  sqrt2 special-case flags
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE; rr_ptr=0; all outputs 0; SQ_DATA released (Z); SQ_ENABLE=0.
//  FSM states and transitions:
//  - IDLE: if any REQ_VALID, grant the first set bit scanning from rr_ptr upward with wrap.
//    - Grant cycle: REQ_READY[g]=1 (combinational, same cycle), operand and id latched.
//    - rr_ptr <= (g+1) mod N_REQ; next state LOAD.
//  - LOAD: SQ_ENABLE=1 and SQ_DATA driven with the latched operand for exactly LOAD_CYC cycles.
//    - Then WAIT; the timeout counter clears to 0.
//  - WAIT: SQ_ENABLE=1; SQ_DATA is Z (the scheduler never drives it outside LOAD).
//    - Completion when SQ_RESULT|SQ_IS_NAN|SQ_IS_PINF|SQ_IS_NINF is sampled high.
//    - On completion, register RSP_DATA (SQ_DATA if SQ_RESULT, else 0) and RSP_FLAGS; go to DONE.
//    - The counter increments every WAIT cycle. At count == TIMEOUT-1 with no completion,
//      go to DONE with RSP_TIMEOUT=1, RSP_DATA=0, RSP_FLAGS=0.
//    - Completion on the same cycle as the timeout: completion wins, RSP_TIMEOUT=0.
//  - DONE: RSP_VALID=1 for one cycle with RSP_ID/DATA/FLAGS/TIMEOUT; SQ_ENABLE=0; go to FLUSH.
//  - FLUSH: SQ_ENABLE=0 for one more cycle so the unit pipeline drains; go to IDLE.
//  RSP_* fields:
//  - Hold their values until the next DONE.
//  - RSP_TIMEOUT, RSP_FLAGS and RSP_DATA are only meaningful while RSP_VALID=1.
//  Latency: grant at cycle t -> LOAD t+1..t+LOAD_CYC -> WAIT.
//  - Completion sampled at cycle c -> RSP_VALID at c+1.
//  - Next grant no earlier than c+3.
//  Fairness and accept rules:
//  - A requester deasserting REQ_VALID before its grant is simply skipped.
//  - REQ_VALID is ignored outside IDLE; REQ_READY is never high outside IDLE.
//  Bus safety: drive enable for SQ_DATA = (state==LOAD) only; no overlap with SQ_RESULT by construction.
//  Reset mid-operation: the unit sees SQ_ENABLE=0 immediately; the in-flight request is dropped with no RSP_VALID.
// TESTING
//  - Single op: REQ_VALID=4'b0001, REQ_DATA[15:0]=16'h4400 (4.0) ->
//    RSP_VALID, RSP_ID=0, RSP_DATA=16'h4000, RSP_FLAGS=0, RSP_TIMEOUT=0.
//  - Specials:
//    - 16'hBC00 (-1.0) -> RSP_FLAGS=3'b100, RSP_DATA=0.
//    - 16'h7C00 (+inf) -> RSP_FLAGS=3'b010.
//    - 16'hFC00 (-inf) -> RSP_FLAGS=3'b100 or 3'b001 per unit; bench compares against the sqrt2 model.
//  - Round-robin: REQ_VALID=4'hF held with distinct operands -> grant order 0,1,2,3,0; each RSP_ID matches its operand.
//  - Timeout: bench model never asserts RESULT or flags ->
//    RSP_VALID exactly TIMEOUT cycles after WAIT entry, RSP_TIMEOUT=1, RSP_DATA=0.
//  - Boundary: completion on the final timeout cycle -> RSP_TIMEOUT=0, normal data returned.
//  - Reset in WAIT: assert RST asynchronously ->
//    - Same edge: SQ_ENABLE=0, SQ_DATA=Z, BUSY=0, no RSP_VALID.
//    - After release: a new request is granted starting at requester 0.

Source files
------------

// File: rtl/sqrt2_sched.sv
// Round-robin scheduler sharing one sqrt2 fp16 square-root unit among
// N_REQ requesters. One operation is in flight at a time. Each operation
// runs grant -> load -> wait -> respond -> flush.
module sqrt2_sched #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int LOAD_CYC = 1,
    parameter int TIMEOUT  = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_REQ-1:0]      REQ_VALID,
    input  logic [16*N_REQ-1:0]   REQ_DATA,
    output logic [N_REQ-1:0]      REQ_READY,
    output logic                  RSP_VALID,
    output logic [ID_W-1:0]       RSP_ID,
    output logic [15:0]           RSP_DATA,
    output logic [2:0]            RSP_FLAGS,
    output logic                  RSP_TIMEOUT,
    output logic                  BUSY,
    inout  wire  [15:0]           SQ_DATA,
    output logic                  SQ_ENABLE,
    input  logic                  SQ_RESULT,
    input  logic                  SQ_IS_NAN,
    input  logic                  SQ_IS_PINF,
    input  logic                  SQ_IS_NINF
);

    localparam int LCW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
    localparam int TOW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DONE,
        S_FLUSH
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] grant_idx;
    logic            grant_any;
    logic            grant_en;
    logic [ID_W-1:0] op_id;
    logic [15:0]     op_data;
    logic [LCW-1:0]  load_cnt;
    logic [TOW-1:0]  wait_cnt;
    logic            done_any;
    logic            load_last;
    logic            wait_last;

    // Pick the first pending requester scanning upward from rr_ptr with wrap.
    // NOTE: every variable written here gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!grant_any && REQ_VALID[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Grant only from IDLE; reset forces the accept strobe low as well.
    assign grant_en  = (state == S_IDLE) && grant_any && !RST;
    assign done_any  = SQ_RESULT | SQ_IS_NAN | SQ_IS_PINF | SQ_IS_NINF;
    assign load_last = (load_cnt == LCW'(LOAD_CYC - 1));
    assign wait_last = (wait_cnt == TOW'(TIMEOUT - 1));

    // One-hot accept strobe, combinational in the grant cycle.
    always_comb begin
        REQ_READY = '0;
        if (grant_en) begin
            REQ_READY[grant_idx] = 1'b1;
        end
    end

    // The operand sits on the shared bus only during LOAD; released otherwise.
    assign SQ_DATA = (state == S_LOAD) ? op_data : 16'hzzzz;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        SQ_ENABLE = 1'b0;
        RSP_VALID = 1'b0;
        BUSY      = 1'b1;
        case (state)
            S_IDLE: begin
                BUSY = 1'b0;
                if (grant_en) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                SQ_ENABLE = 1'b1;
                if (load_last) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                SQ_ENABLE = 1'b1;
                if (done_any || wait_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                RSP_VALID = 1'b1;
                state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant bookkeeping, load/wait counters and the response registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr      <= '0;
            op_id       <= '0;
            op_data     <= '0;
            load_cnt    <= '0;
            wait_cnt    <= '0;
            RSP_ID      <= '0;
            RSP_DATA    <= '0;
            RSP_FLAGS   <= '0;
            RSP_TIMEOUT <= 1'b0;
        end else begin
            if (grant_en) begin
                op_data  <= REQ_DATA[16*grant_idx +: 16];
                op_id    <= grant_idx;
                rr_ptr   <= ID_W'((int'(grant_idx) + 1) % N_REQ);
                load_cnt <= '0;
            end
            if (state == S_LOAD) begin
                load_cnt <= load_cnt + 1'b1;
                wait_cnt <= '0;
            end
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
                // Completion beats a timeout landing on the same cycle.
                if (done_any) begin
                    RSP_ID      <= op_id;
                    RSP_DATA    <= SQ_RESULT ? SQ_DATA : 16'h0000;
                    RSP_FLAGS   <= {SQ_IS_NAN, SQ_IS_PINF, SQ_IS_NINF};
                    RSP_TIMEOUT <= 1'b0;
                end else if (wait_last) begin
                    RSP_ID      <= op_id;
                    RSP_DATA    <= 16'h0000;
                    RSP_FLAGS   <= 3'b000;
                    RSP_TIMEOUT <= 1'b1;
                end
            end
        end
    end

endmodule
